// File: rtl/wave_renderer.sv
// wave_renderer: two-stage multi-channel oscilloscope pixel renderer.
// Stage 1 captures raster position, sample rows and grid flag.
// Stage 2 resolves trace hits by priority and registers the final colour.
module wave_renderer #(
    parameter int unsigned        NUM_CH    = 2,
    parameter int unsigned        DATA_W    = 8,
    parameter int unsigned        XY_W      = 10,
    parameter int unsigned        BASELINE  = 239,
    parameter int unsigned        GRID_LOG2 = 5,
    parameter logic [3*NUM_CH-1:0] CH_RGB   = {3'b111, 3'b110},
    parameter logic [2:0]         GRID_RGB  = 3'b010
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [XY_W-1:0]          x_in,
    input  logic [XY_W-1:0]          y_in,
    input  logic                     de_in,
    input  logic                     hs_in,
    input  logic                     vs_in,
    input  logic [NUM_CH*DATA_W-1:0] data_in,
    input  logic [NUM_CH-1:0]        ch_en,
    input  logic [1:0]               mode,
    output logic [2:0]               rgb_out,
    output logic                     de_out,
    output logic                     hs_out,
    output logic                     vs_out
);

    localparam int unsigned     ROW_W    = XY_W + 1;
    localparam logic [XY_W-1:0] BASE_ROW = XY_W'(BASELINE);

    // Frame-synchronous control shadows
    logic [1:0]        mode_sh_q,  mode_sh_d;
    logic [NUM_CH-1:0] ch_en_sh_q, ch_en_sh_d;

    // Last active-pixel row per channel
    logic [NUM_CH-1:0][XY_W-1:0] prev_row_q, prev_row_d;

    // Stage 1 registers
    logic [XY_W-1:0]             y_s1_q,    y_s1_d;
    logic                        de_s1_q,   de_s1_d;
    logic                        hs_s1_q,   hs_s1_d;
    logic                        vs_s1_q,   vs_s1_d;
    logic                        grid_s1_q, grid_s1_d;
    logic [NUM_CH-1:0][XY_W-1:0] row_s1_q,  row_s1_d;
    logic [NUM_CH-1:0][XY_W-1:0] prev_s1_q, prev_s1_d;

    // Stage 2 (output) registers
    logic [2:0] rgb_q, rgb_d;
    logic       de_q,  de_d;
    logic       hs_q,  hs_d;
    logic       vs_q,  vs_d;

    logic signed [ROW_W-1:0]     diff_c;
    logic [NUM_CH-1:0][XY_W-1:0] row_c;
    logic                        row_start_c;
    logic [NUM_CH-1:0]           hit_c;

    // Latch mode and enable mask only at the top-left pixel
    always_comb begin
        mode_sh_d  = mode_sh_q;
        ch_en_sh_d = ch_en_sh_q;
        if (x_in == '0 && y_in == '0) begin
            mode_sh_d  = mode;
            ch_en_sh_d = ch_en;
        end
    end

    // Convert samples to screen rows, clamping above-screen values to row 0
    always_comb begin
        diff_c = '0;
        row_c  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            diff_c = $signed(ROW_W'(BASELINE)) - $signed(ROW_W'(data_in[DATA_W*k +: DATA_W]));
            row_c[k] = diff_c[ROW_W-1] ? '0 : diff_c[XY_W-1:0];
        end
    end

    // Stage 1: capture pixel context; a row start restarts the segment at the current row
    always_comb begin
        row_start_c = de_in && !de_s1_q;
        y_s1_d      = y_in;
        de_s1_d     = de_in;
        hs_s1_d     = hs_in;
        vs_s1_d     = vs_in;
        grid_s1_d   = (x_in[GRID_LOG2-1:0] == '0) || (y_in[GRID_LOG2-1:0] == '0);
        row_s1_d    = row_c;
        prev_s1_d   = row_start_c ? row_c : prev_row_q;
        prev_row_d  = de_in ? row_c : prev_row_q;
    end

    // Stage 2: per-channel hit test under the shadowed mode and mask
    always_comb begin
        hit_c = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            case (mode_sh_q)
                2'b01: hit_c[k] = (y_s1_q >= row_s1_q[k] && y_s1_q <= prev_s1_q[k]) ||
                                  (y_s1_q >= prev_s1_q[k] && y_s1_q <= row_s1_q[k]);
                2'b10: hit_c[k] = (y_s1_q >= row_s1_q[k] && y_s1_q <= BASE_ROW) ||
                                  (y_s1_q >= BASE_ROW && y_s1_q <= row_s1_q[k]);
                default: hit_c[k] = (y_s1_q == row_s1_q[k]);
            endcase
            hit_c[k] = hit_c[k] && ch_en_sh_q[k];
        end
    end

    // Stage 2: colour select, lowest channel wins, then grid, blanked outside active area
    always_comb begin
        rgb_d = '0;
        if (de_s1_q) begin
            if (grid_s1_q) begin
                rgb_d = GRID_RGB;
            end
            for (int k = NUM_CH - 1; k >= 0; k--) begin
                if (hit_c[k]) begin
                    rgb_d = CH_RGB[3*k +: 3];
                end
            end
        end
        de_d = de_s1_q;
        hs_d = hs_s1_q;
        vs_d = vs_s1_q;
    end

    // All state with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_sh_q  <= '0;
            ch_en_sh_q <= '0;
            prev_row_q <= '0;
            y_s1_q     <= '0;
            de_s1_q    <= 1'b0;
            hs_s1_q    <= 1'b0;
            vs_s1_q    <= 1'b0;
            grid_s1_q  <= 1'b0;
            row_s1_q   <= '0;
            prev_s1_q  <= '0;
            rgb_q      <= '0;
            de_q       <= 1'b0;
            hs_q       <= 1'b0;
            vs_q       <= 1'b0;
        end else begin
            mode_sh_q  <= mode_sh_d;
            ch_en_sh_q <= ch_en_sh_d;
            prev_row_q <= prev_row_d;
            y_s1_q     <= y_s1_d;
            de_s1_q    <= de_s1_d;
            hs_s1_q    <= hs_s1_d;
            vs_s1_q    <= vs_s1_d;
            grid_s1_q  <= grid_s1_d;
            row_s1_q   <= row_s1_d;
            prev_s1_q  <= prev_s1_d;
            rgb_q      <= rgb_d;
            de_q       <= de_d;
            hs_q       <= hs_d;
            vs_q       <= vs_d;
        end
    end

    assign rgb_out = rgb_q;
    assign de_out  = de_q;
    assign hs_out  = hs_q;
    assign vs_out  = vs_q;

endmodule
